// File: rtl/dtm_jtag.sv
// JTAG Debug Transport Module: oversampled TAP controller with IDCODE/DTMCS/DMI/BYPASS
// data registers, launching single DMI request/ready transactions toward the debug module.
module dtm_jtag #(
  parameter logic [31:0] IDCODE = 32'h00000001,
  parameter int          ABITS  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             jtag_tck,
  input  logic             jtag_tms,
  input  logic             jtag_tdi,
  output logic             jtag_tdo,
  output logic             dmi_valid,
  input  logic             dmi_ready,
  output logic             dmi_write,
  output logic [ABITS-1:0] dmi_addr,
  output logic [31:0]      dmi_wdata,
  input  logic [31:0]      dmi_rdata
);

  localparam int DMI_W = ABITS + 34;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {SEL_IDCODE, SEL_DTMCS, SEL_DMI, SEL_BYPASS} dr_sel_e;

  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic             tck_dly_q, tck_dly_d;
  tap_state_e       state_q, state_d, tap_next;
  logic [4:0]       ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [DMI_W-1:0] dr_sr_q, dr_sr_d, dr_shift;
  logic             tdo_q, tdo_d;
  logic             valid_q, valid_d, write_q, write_d, sticky_q, sticky_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d, result_q, result_d, dtmcs_val;
  logic             tck_s, tms_s, tdi_s, tck_rise, tck_fall, busy;
  logic [1:0]       dmi_op;
  dr_sel_e          dr_sel;

  assign tck_s    = sync2_q[2];
  assign tms_s    = sync2_q[1];
  assign tdi_s    = sync2_q[0];
  assign tck_rise = tck_s & ~tck_dly_q;
  assign tck_fall = ~tck_s & tck_dly_q;
  assign busy     = valid_q;
  assign dmi_op   = dr_sr_q[1:0];

  always_comb begin
    sync1_d   = {jtag_tck, jtag_tms, jtag_tdi};
    sync2_d   = sync1_q;
    tck_dly_d = sync2_q[2];
  end

  always_comb begin
    tap_next = state_q;
    case (state_q)
      TLR:      tap_next = tms_s ? TLR      : RTI;
      RTI:      tap_next = tms_s ? SEL_DR   : RTI;
      SEL_DR:   tap_next = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: tap_next = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = tms_s ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: tap_next = tms_s ? UPD_DR   : SHIFT_DR;
      UPD_DR:   tap_next = tms_s ? SEL_DR   : RTI;
      SEL_IR:   tap_next = tms_s ? TLR      : CAP_IR;
      CAP_IR:   tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: tap_next = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = tms_s ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: tap_next = tms_s ? UPD_IR   : SHIFT_IR;
      UPD_IR:   tap_next = tms_s ? SEL_DR   : RTI;
      default:  tap_next = TLR;
    endcase
  end

  // Register selection and the right-shift with tdi entering at the selected length's MSB.
  always_comb begin
    case (ir_q)
      5'h01:   dr_sel = SEL_IDCODE;
      5'h10:   dr_sel = SEL_DTMCS;
      5'h11:   dr_sel = SEL_DMI;
      default: dr_sel = SEL_BYPASS;
    endcase
    dtmcs_val = {20'd0, (sticky_q ? 2'b11 : 2'b00), 6'(ABITS), 4'd1};
    dr_shift  = dr_sr_q >> 1;
    case (dr_sel)
      SEL_IDCODE, SEL_DTMCS: dr_shift[31]       = tdi_s;
      SEL_DMI:               dr_shift[DMI_W-1]  = tdi_s;
      default:               dr_shift[0]        = tdi_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    dr_sr_d  = dr_sr_q;
    tdo_d    = tdo_q;
    valid_d  = valid_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    sticky_d = sticky_q;

    if (valid_q && dmi_ready) begin
      valid_d  = 1'b0;
      result_d = write_q ? wdata_q : dmi_rdata;
    end

    if (tck_rise) begin
      state_d = tap_next;
      case (state_q)
        CAP_IR:   ir_sr_d = 5'b00001;
        SHIFT_IR: ir_sr_d = {tdi_s, ir_sr_q[4:1]};
        CAP_DR: begin
          case (dr_sel)
            SEL_IDCODE: dr_sr_d = DMI_W'(IDCODE);
            SEL_DTMCS:  dr_sr_d = DMI_W'(dtmcs_val);
            SEL_DMI: begin
              dr_sr_d = {addr_q, result_q, ((busy || sticky_q) ? 2'b11 : 2'b00)};
              if (busy) sticky_d = 1'b1;
            end
            default:    dr_sr_d = '0;
          endcase
        end
        SHIFT_DR: dr_sr_d = dr_shift;
        default: ;
      endcase

      if (tap_next == UPD_IR) ir_d = ir_sr_q;

      // A rejected request leaves the bus untouched; only a busy collision marks sticky.
      if (tap_next == UPD_DR) begin
        if (dr_sel == SEL_DTMCS && (dr_sr_q[16] || dr_sr_q[17])) sticky_d = 1'b0;
        if (dr_sel == SEL_DMI && (dmi_op == 2'd1 || dmi_op == 2'd2)) begin
          if (busy) begin
            sticky_d = 1'b1;
          end else if (!sticky_q) begin
            valid_d = 1'b1;
            write_d = (dmi_op == 2'd2);
            addr_d  = dr_sr_q[DMI_W-1:34];
            wdata_d = dr_sr_q[33:2];
          end
        end
      end
    end

    if (tck_fall) begin
      if (state_q == SHIFT_DR)      tdo_d = dr_sr_q[0];
      else if (state_q == SHIFT_IR) tdo_d = ir_sr_q[0];
    end

    if (state_q == TLR) begin
      ir_d     = 5'h01;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      tck_dly_q <= 1'b0;
      state_q   <= TLR;
      ir_q      <= 5'h01;
      ir_sr_q   <= '0;
      dr_sr_q   <= '0;
      tdo_q     <= 1'b0;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      sticky_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      tck_dly_q <= tck_dly_d;
      state_q   <= state_d;
      ir_q      <= ir_d;
      ir_sr_q   <= ir_sr_d;
      dr_sr_q   <= dr_sr_d;
      tdo_q     <= tdo_d;
      valid_q   <= valid_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      result_q  <= result_d;
      sticky_q  <= sticky_d;
    end
  end

  assign jtag_tdo  = tdo_q;
  assign dmi_valid = valid_q;
  assign dmi_write = write_q;
  assign dmi_addr  = addr_q;
  assign dmi_wdata = wdata_q;

endmodule

// File: tb/tb_dtm_jtag.sv
// Directed bench for dtm_jtag: bit-banged JTAG scans against a small DMI responder
// that raises ready one cycle after valid, or stalls on demand.
module tb_dtm_jtag;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jtag_tck = 1'b0, jtag_tms = 1'b1, jtag_tdi = 1'b0;
  logic        jtag_tdo, dmi_valid, dmi_write;
  logic        dmi_ready = 1'b0;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata = 32'h0;

  int checks = 0;
  int passes = 0;

  logic        stall = 1'b0;
  logic        prev_valid = 1'b0;
  int          valid_len = 0;
  int          launches = 0;
  logic        unstable = 1'b0;
  logic [6:0]  snap_addr = '0;
  logic [31:0] snap_wdata = '0;
  logic        snap_write = 1'b0;

  dtm_jtag #(.IDCODE(32'h00000001), .ABITS(7)) dut (
    .clk(clk), .reset(reset),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata)
  );

  always #5 clk = ~clk;

  // Responder: ready follows valid by one cycle; also records each launch and its payload.
  always @(negedge clk) begin
    if (dmi_valid) begin
      valid_len++;
      if (!prev_valid) begin
        launches++;
        snap_addr  = dmi_addr;
        snap_wdata = dmi_wdata;
        snap_write = dmi_write;
      end else if (dmi_addr !== snap_addr || dmi_wdata !== snap_wdata || dmi_write !== snap_write) begin
        unstable = 1'b1;
      end
    end
    dmi_ready  = stall ? 1'b0 : prev_valid;
    prev_valid = dmi_valid;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic tms, input logic tdi, output logic tdo);
    jtag_tms = tms;
    jtag_tdi = tdi;
    #50;
    tdo = jtag_tdo;
    jtag_tck = 1'b1;
    #50;
    jtag_tck = 1'b0;
  endtask

  task automatic goto_idle();
    logic t;
    repeat (5) applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
  endtask

  task automatic shift_ir(input logic [4:0] v);
    logic t;
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) applyStimulus(i == 4, v[i], t);
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
  endtask

  task automatic shift_dr(input logic [40:0] din, input int len, output logic [40:0] dout);
    logic t;
    dout = '0;
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    for (int i = 0; i < len; i++) begin
      applyStimulus(i == len - 1, din[i], t);
      dout[i] = t;
    end
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
  endtask

  function automatic logic [40:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {a, d, op};
  endfunction

  initial begin
    logic [40:0] dout;
    int len0, launch0;

    #23;
    checkOutput("reset_valid", dmi_valid, 1'b0);
    checkOutput("reset_tdo", jtag_tdo, 1'b0);
    checkOutput("reset_addr", dmi_addr, 7'h0);
    #7 reset = 1'b0;

    // IDCODE after reset
    launch0 = launches;
    goto_idle();
    shift_dr(41'h0, 32, dout);
    checkOutput("idcode", dout[31:0], 32'h00000001);
    checkOutput("idcode_no_valid", launches - launch0, 0);

    shift_ir(5'h10);
    shift_dr(41'h0, 32, dout);
    checkOutput("dtmcs", dout[31:0], 32'h00000071);

    // DMI write with single-cycle-late ready
    shift_ir(5'h11);
    len0 = valid_len; launch0 = launches;
    shift_dr(dmi_word(7'h04, 32'hDEADBEEF, 2'd2), 41, dout);
    repeat (10) @(negedge clk);
    checkOutput("wr_launches", launches - launch0, 1);
    checkOutput("wr_valid_len", valid_len - len0, 2);
    checkOutput("wr_write", snap_write, 1'b1);
    checkOutput("wr_addr", snap_addr, 7'h04);
    checkOutput("wr_wdata", snap_wdata, 32'hDEADBEEF);
    checkOutput("wr_stable", unstable, 1'b0);

    // DMI read; its capture still shows the write result
    dmi_rdata = 32'h12345678;
    shift_dr(dmi_word(7'h04, 32'h0, 2'd1), 41, dout);
    checkOutput("wr_cap_op", dout[1:0], 2'd0);
    checkOutput("wr_cap_data", dout[33:2], 32'hDEADBEEF);
    checkOutput("wr_cap_addr", dout[40:34], 7'h04);
    repeat (10) @(negedge clk);
    shift_dr(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    checkOutput("rd_cap_op", dout[1:0], 2'd0);
    checkOutput("rd_cap_data", dout[33:2], 32'h12345678);

    // Stalled responder: busy capture, rejected request, sticky until dmireset
    stall = 1'b1;
    dmi_rdata = 32'hCAFEF00D;
    launch0 = launches;
    shift_dr(dmi_word(7'h05, 32'h0, 2'd1), 41, dout);
    repeat (10) @(negedge clk);
    checkOutput("stall_valid", dmi_valid, 1'b1);
    checkOutput("stall_addr", dmi_addr, 7'h05);
    shift_dr(dmi_word(7'h06, 32'h0, 2'd1), 41, dout);
    checkOutput("busy_cap_op", dout[1:0], 2'd3);
    checkOutput("busy_cap_addr", dout[40:34], 7'h05);
    checkOutput("busy_no_launch", launches - launch0, 1);
    repeat (200) @(negedge clk);
    checkOutput("stall_still_valid", dmi_valid, 1'b1);
    stall = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("stall_done", dmi_valid, 1'b0);
    checkOutput("stall_stable", unstable, 1'b0);
    shift_dr(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    checkOutput("sticky_cap_op", dout[1:0], 2'd3);
    shift_ir(5'h10);
    shift_dr(41'h10000, 32, dout);
    checkOutput("dtmcs_sticky", dout[31:0], 32'h00000C71);
    shift_dr(41'h0, 32, dout);
    checkOutput("dtmcs_cleared", dout[31:0], 32'h00000071);
    shift_ir(5'h11);
    shift_dr(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    checkOutput("clr_cap_op", dout[1:0], 2'd0);
    checkOutput("clr_cap_data", dout[33:2], 32'hCAFEF00D);
    checkOutput("clr_cap_addr", dout[40:34], 7'h05);

    // Async reset during an outstanding request
    stall = 1'b1;
    shift_dr(dmi_word(7'h45, 32'h55AA55AA, 2'd2), 41, dout);
    shift_dr(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_valid", dmi_valid, 1'b1);
    checkOutput("pre_rst_tdo", jtag_tdo, 1'b1);
    checkOutput("pre_rst_wdata", dmi_wdata, 32'h55AA55AA);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_valid", dmi_valid, 1'b0);
    checkOutput("rst_tdo", jtag_tdo, 1'b0);
    checkOutput("rst_write", dmi_write, 1'b0);
    checkOutput("rst_addr", dmi_addr, 7'h0);
    checkOutput("rst_wdata", dmi_wdata, 32'h0);
    stall = 1'b0;
    #7 reset = 1'b0;
    launch0 = launches;
    applyStimulus(1'b0, 1'b0, dout[0]);
    shift_dr(41'h0, 32, dout);
    checkOutput("post_rst_idcode", dout[31:0], 32'h00000001);
    checkOutput("post_rst_no_valid", launches - launch0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dtm_jtag.md
Name: dtm_jtag

Overview:
JTAG Debug Transport Module and the initiator side of the DMI request/ready handshake. It turns scans from an external JTAG probe into single DMI read/write transactions toward the debug module, and returns read data and status on the next scan. JTAG pins are oversampled in the single system clock domain, so no second clock domain is needed.

Parameters:
IDCODE, 32'h00000001, value returned by the IDCODE DR; bit 0 must be 1
ABITS, 7, DMI address width; DMI DR width is ABITS+34

Ports:
clk  input  1  system clock; must run at least 4x jtag_tck frequency
reset  input  1  asynchronous, active-high reset
jtag_tck  input  1  JTAG clock, asynchronous; 2-flop synchronised
jtag_tms  input  1  JTAG mode select, 2-flop synchronised
jtag_tdi  input  1  JTAG data in, 2-flop synchronised
jtag_tdo  output  1  JTAG data out
dmi_valid  output  1  DMI request valid
dmi_ready  input  1  DMI responder ready
dmi_write  output  1  1 = write, 0 = read
dmi_addr  output  ABITS  DMI address
dmi_wdata  output  32  DMI write data
dmi_rdata  input  32  DMI read data, sampled on the handshake cycle

Behaviour:
- Reset (async, active-high):
  - dmi_valid=0, dmi_write=0, dmi_addr=0, dmi_wdata=0, jtag_tdo=0.
  - TAP goes to Test-Logic-Reset; IR=5'h01; sticky=0; result data=0; busy=0.
- Edges: tck rise/fall are detected from the synchronised tck (tck_s, tck_s_d). All TAP activity happens on the clk cycle where an edge is detected.
- TAP state machine: the standard IEEE 1149.1 16-state machine, advanced on each tck rise using synchronised tms. Five consecutive tms=1 reach Test-Logic-Reset from any state.
- Test-Logic-Reset: IR=5'h01 and sticky cleared; an in-flight DMI transaction is not aborted.
- IR: 5 bits; Capture-IR loads 5'b00001; shifts LSB first; the IR register updates in Update-IR.
- IR decode: 5'h01 IDCODE (32b), 5'h10 DTMCS (32b), 5'h11 DMI (ABITS+34b), all other values BYPASS (1b, captures 0).
- Shifting: in Shift-DR/Shift-IR, the selected shift register shifts right on tck rise with tdi entering the MSB. jtag_tdo is driven from shift-register bit 0 on tck fall; otherwise tdo holds its value.
- DTMCS capture value:
  - [3:0]=1 (version); [9:4]=ABITS; [11:10]=dmistat (0, or 3 when sticky); [14:12]=0 (idle); others 0.
  - Update-DR with bit16 (dmireset) or bit17 (dmihardreset) set clears sticky. An in-flight transaction always completes.
- DMI DR layout: [ABITS+33:34]=addr, [33:2]=data, [1:0]=op.
- DMI Capture-DR loads {last addr, result data, status}:
  - status=3 if sticky or busy; if busy at capture, sticky is also set.
  - Otherwise status=0.
- DMI Update-DR, op=1 (read) or op=2 (write):
  - If busy or sticky: no transaction is issued, and sticky is set if busy.
  - Otherwise a transaction is launched: dmi_addr, dmi_wdata and dmi_write load from the DR, and dmi_valid=1 on the clk cycle after the tck-rise cycle entering Update-DR. busy=1.
  - op=0 and op=3 are no-ops.
- Handshake:
  - addr, write and wdata are held stable while dmi_valid=1.
  - On the clk edge where dmi_valid && dmi_ready: dmi_valid goes 0 the next cycle and busy clears. For a read, result data <= dmi_rdata; for a write, result data <= dmi_wdata.
  - dmi_valid must never stay high after the handshake cycle, because the responder re-asserts ready on a held valid.
  - With a responder that returns ready one cycle after valid, valid is high for exactly 2 cycles.
- dmi_ready while dmi_valid=0 is ignored.
- The IDCODE DR captures the IDCODE parameter; the BYPASS DR captures 0.

Test Plan:
1. Reset, then 5x tms=1, enter Shift-DR, shift 32 bits -> tdo stream LSB-first equals 32'h00000001; dmi_valid stays 0 throughout.
2. Load IR=5'h10, scan DTMCS -> 32'h00000071 captured.
3. IR=5'h11, scan addr=7'h04 data=32'hDEADBEEF op=2, with a responder whose ready rises 1 cycle after valid:
   - dmi_valid high for exactly 2 clk cycles with dmi_write=1, dmi_addr=4, dmi_wdata=32'hDEADBEEF.
   - The next scan captures op=0 and data=32'hDEADBEEF.
4. Scan op=1 addr=4, responder returns 32'h12345678 -> the next scan captures data 32'h12345678, op=0.
5. Responder stalls ready for 200 clk cycles:
   - An intervening DMI scan captures op=3; its op=1 update issues no new dmi_valid.
   - Later scans keep op=3 until a DTMCS write with bit16=1 clears sticky; after that, captures return op=0.
6. Assert reset while dmi_valid=1 -> dmi_valid, jtag_tdo and dmi_* go 0 immediately (asynchronously), the TAP sits in Test-Logic-Reset, and a subsequent IDCODE scan is correct.
